// File: rtl/morra_scoreboard.sv
// Morra Cinese scoreboard: per-game round tallies, best-of-N match
// tracking and a PLAY-phase watchdog, fed by the game FSM's registered outputs.
module morra_scoreboard #(
  parameter int CNT_W       = 5,
  parameter int MATCH_GAMES = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic             MATCH_CLR,
  input  logic [1:0]       ROUND,
  input  logic [1:0]       GAME,
  output logic [CNT_W-1:0] P1_ROUNDS,
  output logic [CNT_W-1:0] P2_ROUNDS,
  output logic [CNT_W-1:0] DRAWS,
  output logic [CNT_W-1:0] INVALIDS,
  output logic             GAME_DONE,
  output logic [1:0]       LAST_GAME,
  output logic [3:0]       P1_GAMES,
  output logic [3:0]       P2_GAMES,
  output logic [1:0]       MATCH,
  output logic             MATCH_DONE,
  output logic             TIMEOUT_ERR,
  output logic             BUSY
);

  localparam int WIN_TARGET = MATCH_GAMES / 2 + 1;
  localparam int WD_W       = $clog2(TIMEOUT_CYC);

  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [3:0]       WIN_T   = 4'(WIN_TARGET);
  localparam logic [3:0]       MG_T    = 4'(MATCH_GAMES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SKIP = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [WD_W-1:0]  r_wd;
  logic [CNT_W-1:0] r_p1r;
  logic [CNT_W-1:0] r_p2r;
  logic [CNT_W-1:0] r_drw;
  logic [CNT_W-1:0] r_inv;
  logic             r_gdone;
  logic [1:0]       r_last;
  logic [3:0]       r_p1g;
  logic [3:0]       r_p2g;
  logic [3:0]       r_gp;
  logic [1:0]       r_match;
  logic             r_mdone;
  logic             r_terr;
  logic             r_busy;

  logic [1:0]       w_state;
  logic [WD_W-1:0]  w_wd;
  logic [CNT_W-1:0] w_p1r;
  logic [CNT_W-1:0] w_p2r;
  logic [CNT_W-1:0] w_drw;
  logic [CNT_W-1:0] w_inv;
  logic             w_gdone;
  logic [1:0]       w_last;
  logic [3:0]       w_p1g;
  logic [3:0]       w_p2g;
  logic [3:0]       w_gp;
  logic [1:0]       w_match;
  logic             w_mdone;
  logic             w_terr;
  logic             w_busy;

  logic [3:0]       w_p1g_inc;
  logic [3:0]       w_p2g_inc;
  logic [3:0]       w_gp_inc;
  logic             w_mend;
  logic [1:0]       w_mres;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Tally as it would look if the sampled GAME result were accepted
  assign w_p1g_inc = r_p1g + {3'b000, GAME == 2'b01};
  assign w_p2g_inc = r_p2g + {3'b000, GAME == 2'b10};
  assign w_gp_inc  = r_gp + 4'd1;

  assign w_mend = (w_p1g_inc >= WIN_T) ||
                  (w_p2g_inc >= WIN_T) ||
                  (w_gp_inc >= MG_T);

  always_comb begin
    w_mres = 2'b11;
    if (w_p1g_inc > w_p2g_inc) begin
      w_mres = 2'b01;
    end else if (w_p2g_inc > w_p1g_inc) begin
      w_mres = 2'b10;
    end
  end

  always_comb begin
    w_state = r_state;
    w_wd    = r_wd;
    w_p1r   = r_p1r;
    w_p2r   = r_p2r;
    w_drw   = r_drw;
    w_inv   = r_inv;
    w_gdone = 1'b0;
    w_last  = r_last;
    w_p1g   = r_p1g;
    w_p2g   = r_p2g;
    w_gp    = r_gp;
    w_match = r_match;
    w_mdone = r_mdone;
    w_terr  = r_terr;

    if (START) begin
      w_state = S_SKIP;
      w_p1r   = '0;
      w_p2r   = '0;
      w_drw   = '0;
      w_inv   = '0;
      w_last  = 2'b00;
      w_terr  = 1'b0;
      if (r_mdone) begin
        w_p1g   = 4'd0;
        w_p2g   = 4'd0;
        w_gp    = 4'd0;
        w_match = 2'b00;
        w_mdone = 1'b0;
      end
    end else begin
      unique case (r_state)
        S_SKIP: begin
          w_state = S_PLAY;
          w_wd    = '0;
        end
        S_PLAY: begin
          if (GAME == 2'b00) begin
            unique case (ROUND)
              2'b01:   w_p1r = sat_inc(r_p1r);
              2'b10:   w_p2r = sat_inc(r_p2r);
              2'b11:   w_drw = sat_inc(r_drw);
              default: w_inv = sat_inc(r_inv);
            endcase
            if (r_wd == WD_LAST) begin
              w_terr  = 1'b1;
              w_state = S_IDLE;
            end else begin
              w_wd = r_wd + 1'b1;
            end
          end else begin
            w_last  = GAME;
            w_gdone = 1'b1;
            w_state = S_DONE;
            w_p1g   = w_p1g_inc;
            w_p2g   = w_p2g_inc;
            w_gp    = w_gp_inc;
            if (w_mend) begin
              w_mdone = 1'b1;
              w_match = w_mres;
            end
          end
        end
        S_IDLE: ;
        S_DONE: ;
      endcase
    end

    // Clearing the match overrides any tally update taken this cycle
    if (MATCH_CLR) begin
      w_p1g   = 4'd0;
      w_p2g   = 4'd0;
      w_gp    = 4'd0;
      w_match = 2'b00;
      w_mdone = 1'b0;
    end

    w_busy = (w_state == S_SKIP) || (w_state == S_PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wd    <= '0;
      r_p1r   <= '0;
      r_p2r   <= '0;
      r_drw   <= '0;
      r_inv   <= '0;
      r_gdone <= 1'b0;
      r_last  <= 2'b00;
      r_p1g   <= 4'd0;
      r_p2g   <= 4'd0;
      r_gp    <= 4'd0;
      r_match <= 2'b00;
      r_mdone <= 1'b0;
      r_terr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_wd    <= w_wd;
      r_p1r   <= w_p1r;
      r_p2r   <= w_p2r;
      r_drw   <= w_drw;
      r_inv   <= w_inv;
      r_gdone <= w_gdone;
      r_last  <= w_last;
      r_p1g   <= w_p1g;
      r_p2g   <= w_p2g;
      r_gp    <= w_gp;
      r_match <= w_match;
      r_mdone <= w_mdone;
      r_terr  <= w_terr;
      r_busy  <= w_busy;
    end
  end

  assign P1_ROUNDS   = r_p1r;
  assign P2_ROUNDS   = r_p2r;
  assign DRAWS       = r_drw;
  assign INVALIDS    = r_inv;
  assign GAME_DONE   = r_gdone;
  assign LAST_GAME   = r_last;
  assign P1_GAMES    = r_p1g;
  assign P2_GAMES    = r_p2g;
  assign MATCH       = r_match;
  assign MATCH_DONE  = r_mdone;
  assign TIMEOUT_ERR = r_terr;
  assign BUSY        = r_busy;

endmodule
